// File: rtl/stopwatch_lap_ctrl_pkg.sv
// Shared types and defaults for the stopwatch lap controller slice.
// State encodings are fixed here so debug tooling can decode them.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOPPED  = 2'b00,
        COUNTING = 2'b01,
        BLINK    = 2'b11
    } sw_state_t;

    localparam int unsigned SW_MAX_COUNT_DEF = 99;

endpackage

// File: rtl/stopwatch_lap_ctrl_if.sv
// Button/display bundle between the board-side controller and the
// stopwatch core. master drives the buttons, slave is the core.
interface stopwatch_lap_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             tick;
    logic             start;
    logic             stop;
    logic             clear;
    logic             count_down;
    logic             lap;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] display;
    logic             running;
    logic             blink;
    logic             done;
    logic             lap_active;
    logic             dir_down;

    modport master (
        output tick, start, stop, clear, count_down, lap, load_val,
        input  count, display, running, blink, done, lap_active, dir_down
    );

    modport slave (
        input  tick, start, stop, clear, count_down, lap, load_val,
        output count, display, running, blink, done, lap_active, dir_down
    );
endinterface

// File: rtl/stopwatch_lap_ctrl_counter.sv
// Saturating up/down counter in [0, MAX_COUNT] with synchronous load.
// Flags whether the current or the next stepped value hits term_val.
module sw_updown_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_COUNT = SW_MAX_COUNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             down,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             at_term,
    output logic             next_term
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] nxt;

    // next stepped value, clamped at both ends of the range
    always_comb begin
        nxt = count;
        if (down) begin
            nxt = (count == '0) ? '0 : count - ONE;
        end else begin
            nxt = (count >= MAXV) ? MAXV : count + ONE;
        end
    end

    assign at_term   = (count == term_val);
    assign next_term = (nxt == term_val);

    // count register: load wins over step
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= nxt;
        end
    end
endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control FSM with count register, lap capture and
// terminal-count blink generator.
// Optional build macro: STOPWATCH_AUTOWRAP_EN (wrap to start value on
// terminal instead of entering BLINK; blink then stays 0).
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MAX_COUNT   = SW_MAX_COUNT_DEF,
    parameter int unsigned BLINK_TICKS = 50
) (
    input  logic                clk,
    input  logic                reset,
    stopwatch_lap_ctrl_if.slave bus
);
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_COUNT);
    localparam int unsigned      BW    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0]    BLAST = BW'(BLINK_TICKS - 1);

    sw_state_t        state;
    logic             dir_down;
    logic [WIDTH-1:0] lap_val;
    logic             lap_active;
    logic             blink;
    logic             done;
    logic [BW-1:0]    bcnt;

    logic [WIDTH-1:0] count;
    logic             at_term;
    logic             next_term;
    logic             term_hit;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_en;
    logic [WIDTH-1:0] ld;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s0_new;

    assign ld       = (bus.load_val > MAXV) ? MAXV : bus.load_val;
    assign term_val = dir_down ? '0 : MAXV;
    assign s0       = dir_down ? ld : '0;
    assign s0_new   = bus.count_down ? ld : '0;

`ifdef STOPWATCH_AUTOWRAP_EN
    // wrap happens on the tick after the terminal value is shown
    assign term_hit = at_term;
`else
    assign term_hit = at_term | next_term;
`endif

    sw_updown_counter #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .load_val  (cnt_load_val),
        .en        (cnt_en),
        .down      (dir_down),
        .term_val  (term_val),
        .count     (count),
        .at_term   (at_term),
        .next_term (next_term)
    );

    // counter control derived from the current state and buttons
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = s0;
        cnt_en       = 1'b0;
        case (state)
            STOPPED: begin
                cnt_load     = bus.clear;
                cnt_load_val = s0_new;
            end
            COUNTING: begin
                cnt_en = bus.tick;
`ifdef STOPWATCH_AUTOWRAP_EN
                cnt_load = bus.tick && term_hit;
`else
                cnt_load = 1'b0;
`endif
            end
            BLINK: begin
                cnt_load = bus.start && !bus.stop;
            end
            default: ;
        endcase
    end

    // FSM, lap register, blink generator and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= STOPPED;
            dir_down   <= 1'b0;
            lap_val    <= '0;
            lap_active <= 1'b0;
            blink      <= 1'b0;
            done       <= 1'b0;
            bcnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                STOPPED: begin
                    dir_down <= bus.count_down;
                    if (bus.clear) begin
                        lap_active <= 1'b0;
                    end
                    if (bus.start && !bus.stop && !bus.clear) begin
                        state <= COUNTING;
                    end
                end
                COUNTING: begin
                    if (bus.lap) begin
                        if (!lap_active) begin
                            lap_val    <= count;
                            lap_active <= 1'b1;
                        end else begin
                            lap_active <= 1'b0;
                        end
                    end
                    if (bus.tick && term_hit) begin
                        done <= 1'b1;
`ifdef STOPWATCH_AUTOWRAP_EN
                        state <= COUNTING;
`else
                        state <= BLINK;
                        blink <= 1'b1;
                        bcnt  <= '0;
`endif
                    end else if (bus.stop && !bus.start) begin
                        state <= STOPPED;
                    end
                end
                BLINK: begin
                    if (bus.start && !bus.stop) begin
                        state <= COUNTING;
                        blink <= 1'b0;
                    end else if (bus.stop && !bus.start) begin
                        state <= STOPPED;
                        blink <= 1'b0;
                    end else if (bus.tick) begin
                        if (bcnt == BLAST) begin
                            bcnt  <= '0;
                            blink <= ~blink;
                        end else begin
                            bcnt <= bcnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state <= STOPPED;
                    blink <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count      = count;
    assign bus.display    = lap_active ? lap_val : count;
    assign bus.running    = (state == COUNTING);
    assign bus.blink      = blink;
    assign bus.done       = done;
    assign bus.lap_active = lap_active;
    assign bus.dir_down   = dir_down;
endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Self-checking bench for stopwatch_lap_ctrl (WIDTH=8, MAX_COUNT=9,
// BLINK_TICKS=2, one tick every 4 clk). Honours STOPWATCH_AUTOWRAP_EN.
module tb_stopwatch_lap_ctrl;

    typedef struct packed {
        logic [7:0] count;
        logic [7:0] display;
        logic       running;
        logic       blink;
        logic       done;
        logic       lap_active;
        logic       dir_down;
    } outs_t;

    typedef struct {
        string       name;
        int unsigned pre;
        logic [6:0]  bits;
        logic [7:0]  lv;
        outs_t       exp;
    } vec_t;

    // input bits: rst tick start stop clear count_down lap
    localparam logic [6:0] RST = 7'b1000000;
    localparam logic [6:0] TK  = 7'b0100000;
    localparam logic [6:0] ST  = 7'b0010000;
    localparam logic [6:0] SP  = 7'b0001000;
    localparam logic [6:0] CL  = 7'b0000100;
    localparam logic [6:0] CD  = 7'b0000010;
    localparam logic [6:0] LP  = 7'b0000001;
    localparam logic [6:0] NO  = 7'b0000000;
    // flags: running blink done lap_active dir_down
    localparam logic [4:0] F_RUN = 5'b10000;
    localparam logic [4:0] F_BLK = 5'b01000;
    localparam logic [4:0] F_DN  = 5'b00100;
    localparam logic [4:0] F_LAP = 5'b00010;
    localparam logic [4:0] F_DIR = 5'b00001;
    localparam logic [4:0] F_0   = 5'b00000;

    logic clk;
    logic reset;

    stopwatch_lap_ctrl_if #(.WIDTH(8)) bus ();

    stopwatch_lap_ctrl #(
        .WIDTH       (8),
        .MAX_COUNT   (9),
        .BLINK_TICKS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t  vecs[$];
    outs_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    function automatic outs_t mko(input logic [7:0] c, input logic [7:0] d, input logic [4:0] f);
        outs_t o;
        o.count   = c;
        o.display = d;
        {o.running, o.blink, o.done, o.lap_active, o.dir_down} = f;
        return o;
    endfunction

    task automatic add(input string nm, input int unsigned pre, input logic [6:0] b,
                       input logic [7:0] lv, input logic [7:0] c, input logic [7:0] d,
                       input logic [4:0] f);
        vec_t v;
        v.name = nm;
        v.pre  = pre;
        v.bits = b;
        v.lv   = lv;
        v.exp  = mko(c, d, f);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [6:0] b, input logic [7:0] lv);
        reset          = b[6];
        bus.tick       = b[5];
        bus.start      = b[4];
        bus.stop       = b[3];
        bus.clear      = b[2];
        bus.count_down = b[1];
        bus.lap        = b[0];
        bus.load_val   = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm);
        outs_t act;
        outs_t exp;
        act.count      = bus.count;
        act.display    = bus.display;
        act.running    = bus.running;
        act.blink      = bus.blink;
        act.done       = bus.done;
        act.lap_active = bus.lap_active;
        act.dir_down   = bus.dir_down;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got count=%0d", nm, act.count);
        end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got count=%0d display=%0d run=%b blink=%b done=%b lap=%b dir=%b, expected count=%0d display=%0d run=%b blink=%b done=%b lap=%b dir=%b",
                         nm, act.count, act.display, act.running, act.blink, act.done,
                         act.lap_active, act.dir_down, exp.count, exp.display, exp.running,
                         exp.blink, exp.done, exp.lap_active, exp.dir_down);
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        repeat (v.pre) drive(v.bits & CD, v.lv);
        sb.push_back(v.exp);
        drive(v.bits, v.lv);
        check(v.name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic bl_exp[4];
        bl_exp = '{1'b1, 1'b0, 1'b0, 1'b1};

        // reset state
        drive(RST, 8'd0);
        sb.push_back(mko(8'd0, 8'd0, F_0));
        drive(RST, 8'd0);
        check("reset");

`ifdef STOPWATCH_AUTOWRAP_EN
        add("aw_start", 0, ST, 8'd0, 8'd0, 8'd0, F_RUN);
        for (int k = 1; k <= 9; k++) add("aw_up", 3, TK, 8'd0, 8'(k), 8'(k), F_RUN);
        add("aw_wrap", 3, TK, 8'd0, 8'd0, 8'd0, F_RUN | F_DN);
        add("aw_done_clr", 0, NO, 8'd0, 8'd0, 8'd0, F_RUN);
        add("aw_tick", 3, TK, 8'd0, 8'd1, 8'd1, F_RUN);
`else
        // up count to blink
        add("t1_start", 0, ST, 8'd0, 8'd0, 8'd0, F_RUN);
        for (int k = 1; k <= 8; k++) add("t1_up", 3, TK, 8'd0, 8'(k), 8'(k), F_RUN);
        add("t1_term", 3, TK, 8'd0, 8'd9, 8'd9, F_BLK | F_DN);
        add("t1_done_clr", 0, NO, 8'd0, 8'd9, 8'd9, F_BLK);
        for (int k = 0; k < 4; k++)
            add("t1_blink", 3, TK, 8'd0, 8'd9, 8'd9, bl_exp[k] ? F_BLK : F_0);
        add("t1_stop", 0, SP, 8'd0, 8'd9, 8'd9, F_0);
        // down count from clamped load
        add("t2_clear", 0, CL | CD, 8'd200, 8'd9, 8'd9, F_DIR);
        add("t2_start", 0, ST | CD, 8'd200, 8'd9, 8'd9, F_RUN | F_DIR);
        for (int k = 1; k <= 8; k++)
            add("t2_down", 3, TK | CD, 8'd200, 8'(9 - k), 8'(9 - k), F_RUN | F_DIR);
        add("t2_term", 3, TK | CD, 8'd200, 8'd0, 8'd0, F_BLK | F_DN | F_DIR);
        add("t2_restart", 0, ST | CD, 8'd200, 8'd9, 8'd9, F_RUN | F_DIR);
        add("t2_stop", 0, SP | CD, 8'd200, 8'd9, 8'd9, F_DIR);
        add("t2_clear_up", 0, CL, 8'd200, 8'd0, 8'd0, F_0);
        // lap capture / release
        add("t3_start", 0, ST, 8'd0, 8'd0, 8'd0, F_RUN);
        for (int k = 1; k <= 4; k++) add("t3_up", 3, TK, 8'd0, 8'(k), 8'(k), F_RUN);
        add("t3_lap1", 0, LP, 8'd0, 8'd4, 8'd4, F_RUN | F_LAP);
        for (int k = 5; k <= 7; k++) add("t3_frozen", 3, TK, 8'd0, 8'(k), 8'd4, F_RUN | F_LAP);
        add("t3_lap2", 0, LP, 8'd0, 8'd7, 8'd7, F_RUN);
        add("t3_lap3", 0, LP, 8'd0, 8'd7, 8'd7, F_RUN | F_LAP);
        add("t3_tick", 3, TK, 8'd0, 8'd8, 8'd7, F_RUN | F_LAP);
        add("t3_stop", 0, SP, 8'd0, 8'd8, 8'd7, F_LAP);
        add("t3_lap_stopped", 0, LP, 8'd0, 8'd8, 8'd7, F_LAP);
        add("t3_clear", 0, CL, 8'd0, 8'd0, 8'd0, F_0);
        // stop coincident with tick, and with terminal tick
        add("t4_start", 0, ST, 8'd0, 8'd0, 8'd0, F_RUN);
        for (int k = 1; k <= 3; k++) add("t4_up", 3, TK, 8'd0, 8'(k), 8'(k), F_RUN);
        add("t4_stop_tick", 3, TK | SP, 8'd0, 8'd4, 8'd4, F_0);
        add("t4_restart", 0, ST, 8'd0, 8'd4, 8'd4, F_RUN);
        for (int k = 5; k <= 8; k++) add("t4_up2", 3, TK, 8'd0, 8'(k), 8'(k), F_RUN);
        add("t4_term_stop", 3, TK | SP, 8'd0, 8'd9, 8'd9, F_BLK | F_DN);
        add("t4_both", 0, ST | SP, 8'd0, 8'd9, 8'd9, F_BLK);
        // reset while in BLINK
        add("t5_reset", 0, RST, 8'd0, 8'd0, 8'd0, F_0);
        // load below the clamp
        add("t6_clear", 0, CL | CD, 8'd5, 8'd5, 8'd5, F_DIR);
        add("t6_start", 0, ST | CD, 8'd5, 8'd5, 8'd5, F_RUN | F_DIR);
        add("t6_tick", 3, TK | CD, 8'd5, 8'd4, 8'd4, F_RUN | F_DIR);
        add("t6_stop", 0, SP | CD, 8'd5, 8'd4, 8'd4, F_DIR);
`endif

        foreach (vecs[i]) run_vec(vecs[i]);

`ifndef STOPWATCH_AUTOWRAP_EN
        // clamp boundary around MAX_COUNT, then direction back to up
        sb.push_back(mko(8'd9, 8'd9, F_DIR));
        drive(CL | CD, 8'd10);
        check("clamp_10");
        sb.push_back(mko(8'd8, 8'd8, F_DIR));
        drive(CL | CD, 8'd8);
        check("load_8");
        sb.push_back(mko(8'd0, 8'd0, F_0));
        drive(CL, 8'd8);
        check("clear_up");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
